// File: rtl/alu_board_top_if.sv
// Board I/O bundle for alu_board_top: slide switches, push-buttons and LEDs.
// The board side (master) drives switches/buttons; the design (slave) drives LEDs.
interface alu_board_top_if #(
  parameter int NB_SW   = 8,
  parameter int NB_BTN  = 3,
  parameter int NB_LEDS = 8
);
  logic [NB_SW-1:0]   i_sw;
  logic [NB_BTN-1:0]  i_btn;
  logic [NB_LEDS-1:0] o_led;

  modport master (output i_sw, output i_btn, input o_led);
  modport slave  (input i_sw, input i_btn, output o_led);
endinterface

// File: rtl/alu_board_top.sv
// alu_board_top: switches are captured into operand A, operand B and op-code
// registers by three buttons; a combinational 8-bit signed ALU drives the LEDs.
// Optional macro BTN_EDGE_EN: buttons load once per rising edge (two-edge
// latency) instead of reloading on every edge while held (one-edge latency).
module alu_board_top #(
  parameter int NB_SW   = 8,
  parameter int NB_BTN  = 3,
  parameter int NB_LEDS = 8,
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic            i_clk,
  input  logic            i_reset,
  alu_board_top_if.slave  bus
);

  localparam logic [NB_OP-1:0] OP_ADD = 6'b100000;
  localparam logic [NB_OP-1:0] OP_SUB = 6'b100010;
  localparam logic [NB_OP-1:0] OP_AND = 6'b100100;
  localparam logic [NB_OP-1:0] OP_OR  = 6'b100101;
  localparam logic [NB_OP-1:0] OP_XOR = 6'b100110;
  localparam logic [NB_OP-1:0] OP_NOR = 6'b100111;
  localparam logic [NB_OP-1:0] OP_SRA = 6'b000011;
  localparam logic [NB_OP-1:0] OP_SRL = 6'b000010;

  logic [2:0]         w_load;
  logic [NB_SW-1:0]   w_sw;
  logic [NB_DATA-1:0] r_a;
  logic [NB_DATA-1:0] r_b;
  logic [NB_OP-1:0]   r_op;
  logic [NB_DATA-1:0] w_result;

`ifdef BTN_EDGE_EN
  // The switch value is delayed alongside the load strobe so the register
  // captures what was on the switches when the button rose.
  logic [2:0]       r_btn_d;
  logic [2:0]       r_load;
  logic [NB_SW-1:0] r_sw;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn_edge
      // Per-button delay register and registered rising-edge strobe
      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          r_btn_d[gi] <= 1'b0;
          r_load[gi]  <= 1'b0;
        end else begin
          r_btn_d[gi] <= bus.i_btn[gi];
          r_load[gi]  <= bus.i_btn[gi] & ~r_btn_d[gi];
        end
      end
    end
  endgenerate

  // Switch snapshot paired with the edge strobe
  always_ff @(posedge i_clk) begin
    if (i_reset) r_sw <= '0;
    else         r_sw <= bus.i_sw;
  end

  assign w_load = r_load;
  assign w_sw   = r_sw;
`else
  assign w_load = bus.i_btn[2:0];
  assign w_sw   = bus.i_sw;
`endif

  // Operand and op-code registers; reset wins over any button
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_a  <= '0;
      r_b  <= '0;
      r_op <= '0;
    end else begin
      if (w_load[0]) r_a  <= w_sw[NB_DATA-1:0];
      if (w_load[1]) r_b  <= w_sw[NB_DATA-1:0];
      if (w_load[2]) r_op <= w_sw[NB_OP-1:0];
    end
  end

  // Combinational ALU; unsigned shift amounts at or beyond the width saturate
  // naturally (sign fill for SRA, zero for SRL)
  always_comb begin
    w_result = '0;
    case (r_op)
      OP_ADD:  w_result = r_a + r_b;
      OP_SUB:  w_result = r_a - r_b;
      OP_AND:  w_result = r_a & r_b;
      OP_OR:   w_result = r_a | r_b;
      OP_XOR:  w_result = r_a ^ r_b;
      OP_NOR:  w_result = ~(r_a | r_b);
      OP_SRA:  w_result = $unsigned($signed(r_a) >>> r_b);
      OP_SRL:  w_result = r_a >> r_b;
      default: w_result = '0;
    endcase
  end

  assign bus.o_led = w_result;

endmodule

// File: tb/tb_alu_board_top.sv
// Testbench for alu_board_top: directed vector table, hand-written corner
// sequences and randomized transactions against an arithmetic reference model.
module tb_alu_board_top;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_board_top_if #(.NB_SW(8), .NB_BTN(3), .NB_LEDS(8)) bus ();

  alu_board_top dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[14];

  // Reference model from the operation rules, using plain integer arithmetic
  function automatic logic [7:0] model(input int a, input int b, input int op);
    int sa;
    int r;
    sa = (a >= 128) ? a - 256 : a;
    case (op)
      32: r = a + b;
      34: r = a - b + 256;
      36: r = a & b;
      37: r = a | b;
      38: r = a ^ b;
      39: r = 255 - (a | b);
      3:  begin
            if (b >= 8) r = (sa < 0) ? 255 : 0;
            else begin
              // floor division by 2^b
              r = (sa >= 0) ? sa / (1 << b) : -((-sa + (1 << b) - 1) / (1 << b));
              r = r + 256;
            end
          end
      2:  r = (b >= 8) ? 0 : a / (1 << b);
      default: r = 0;
    endcase
    return r[7:0];
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: o_led=%02h expected=%02h", name, got, exp);
    end
  endtask

  // One-cycle button press, then an idle edge so both load modes have settled
  task automatic press(input logic [2:0] btn, input logic [7:0] sw);
    @(negedge clk);
    bus.i_sw  = sw;
    bus.i_btn = btn;
    @(posedge clk);
    #1 bus.i_btn = 3'b000;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_all(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    press(3'b001, a);
    press(3'b010, b);
    press(3'b100, {2'b00, op});
  endtask

  logic [7:0] ra, rb, rexp;
  logic [5:0] rop;
  logic [5:0] ops[8];
  logic [7:0] hold_exp;

  initial begin
    rst = 1'b1;
    bus.i_sw  = 8'($urandom);
    bus.i_btn = 3'($urandom);

    vecs[0]  = '{8'd10,  8'd5,    6'b100000, 8'd15};
    vecs[1]  = '{8'd15,  8'd5,    6'b100010, 8'd10};
    vecs[2]  = '{8'd5,   8'd15,   6'b100010, 8'hF6};
    vecs[3]  = '{8'hF0,  8'h3C,   6'b100100, 8'h30};
    vecs[4]  = '{8'hF0,  8'h3C,   6'b100101, 8'hFC};
    vecs[5]  = '{8'hF0,  8'h3C,   6'b100110, 8'hCC};
    vecs[6]  = '{8'hF0,  8'h3C,   6'b100111, 8'h03};
    vecs[7]  = '{8'h80,  8'd2,    6'b000011, 8'hE0};
    vecs[8]  = '{8'h80,  8'd2,    6'b000010, 8'h20};
    vecs[9]  = '{8'h80,  8'd9,    6'b000011, 8'hFF};
    vecs[10] = '{8'h80,  8'd9,    6'b000010, 8'h00};
    vecs[11] = '{8'hF0,  8'h3C,   6'b111111, 8'h00};
    vecs[12] = '{8'hFF,  8'd1,    6'b100000, 8'h00};
    vecs[13] = '{8'h7F,  8'd8,    6'b000011, 8'h00};

    ops = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
            6'b100110, 6'b100111, 6'b000011, 6'b000010};

    // Reset with random switches and buttons
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.i_sw  = 8'($urandom);
      bus.i_btn = 3'($urandom);
      @(negedge clk);
      check("reset_active", bus.o_led, 8'h00);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.i_btn = 3'b000;
    bus.i_sw  = 8'hA5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("after_reset_idle", bus.o_led, 8'h00);
    $display("reset: o_led=%02h", bus.o_led);

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      load_all(vecs[i].a, vecs[i].b, vecs[i].op);
      check($sformatf("vec%0d", i), bus.o_led, vecs[i].exp);
      $display("vec%0d a=%02h b=%02h op=%06b o_led=%02h exp=%02h",
               i, vecs[i].a, vecs[i].b, vecs[i].op, bus.o_led, vecs[i].exp);
    end

    // Two buttons together load A and B from the same switch value
    press(3'b011, 8'd7);
    press(3'b100, 8'b00100000);
    check("dual_load_add", bus.o_led, 8'd14);
    $display("dual load: o_led=%02h", bus.o_led);

    // Switches changing with no button pressed leave the result unchanged
    @(negedge clk);
    bus.i_sw = 8'h55;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("hold_no_button", bus.o_led, 8'd14);

    // Held button while switches step 1->2->3
    press(3'b010, 8'd0);
    press(3'b100, 8'b00100000);
    @(negedge clk);
    bus.i_btn = 3'b001;
    bus.i_sw  = 8'd1;
    @(posedge clk);
    #1 bus.i_sw = 8'd2;
    @(posedge clk);
    #1 bus.i_sw = 8'd3;
    @(posedge clk);
    #1 bus.i_btn = 3'b000;
    repeat (2) @(posedge clk);
    @(negedge clk);
`ifdef BTN_EDGE_EN
    hold_exp = 8'd1;
`else
    hold_exp = 8'd3;
`endif
    check("held_button", bus.o_led, hold_exp);
    $display("held button: o_led=%02h exp=%02h", bus.o_led, hold_exp);

    // Reset mid-sequence with a button pressed: reset wins, all clear
    load_all(8'd20, 8'd22, 6'b100000);
    check("pre_midreset", bus.o_led, 8'd42);
    @(negedge clk);
    rst = 1'b1;
    bus.i_btn = 3'b111;
    bus.i_sw  = 8'h21;
    @(posedge clk);
    @(negedge clk);
    check("midreset", bus.o_led, 8'h00);
    rst = 1'b0;
    bus.i_btn = 3'b000;
    press(3'b100, 8'b00100000);
    check("post_reset_regs_clear", bus.o_led, 8'h00);
    press(3'b001, 8'd9);
    check("post_reset_load", bus.o_led, 8'd9);
    $display("mid reset: o_led=%02h", bus.o_led);

    // Randomized transactions against the reference model
    for (int i = 0; i < 40; i++) begin
      ra  = 8'($urandom);
      rb  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 12)) : 8'($urandom);
      rop = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
      rexp = model(int'(ra), int'(rb), int'(rop));
      load_all(ra, rb, rop);
      check($sformatf("rand%0d", i), bus.o_led, rexp);
      $display("rand%0d a=%02h b=%02h op=%06b o_led=%02h exp=%02h",
               i, ra, rb, rop, bus.o_led, rexp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_board_top.md
# alu_board_top

Board-level wrapper around a combinational 8-bit ALU. Operand A, operand B and a 6-bit operation code are captured from the slide switches into registers by three push-buttons. The ALU result of the stored operands and operation drives the LEDs. This is the top of the FPGA design and connects directly to board switches, buttons and LEDs.

## Interface
- NB_SW, 8: switch bus width.
- NB_BTN, 3: button bus width; only bits [2:0] are used.
- NB_LEDS, 8: LED bus width; must equal NB_DATA.
- NB_DATA, 8: operand and result width.
- NB_OP, 6: operation code width.

One clock; reset is synchronous and active-high.

- i_clk, in, 1: system clock, rising-edge active.
- i_reset, in, 1: synchronous active-high reset.
- i_sw, in, NB_SW: operand and op-code source.
- i_btn, in, NB_BTN: [0] load A, [1] load B, [2] load op.
- o_led, out, NB_LEDS: ALU result.

## Operation
- Registers:
  - reg_a and reg_b, each NB_DATA wide, loaded from i_sw[NB_DATA-1:0].
  - reg_op, NB_OP wide, loaded from i_sw[NB_OP-1:0].
- Loads:
  - i_btn[0] loads reg_a, i_btn[1] loads reg_b, i_btn[2] loads reg_op.
  - Each button acts independently. Several buttons high together load all selected registers from the same i_sw value.
  - A register with its button low holds its value.
- ALU is purely combinational on reg_a, reg_b, reg_op. Operands are treated as two's-complement signed.
- Operations; results wrap modulo 2^NB_DATA, with no carry or overflow output:
  - 6'b100000 ADD: A+B.
  - 6'b100010 SUB: A−B.
  - 6'b100100 AND: A&B.
  - 6'b100101 OR: A|B.
  - 6'b100110 XOR: A^B.
  - 6'b100111 NOR: ~(A|B).
  - 6'b000011 SRA: A arithmetic-right-shifted by unsigned B. B ≥ NB_DATA gives all sign bits.
  - 6'b000010 SRL: A logical-right-shifted by unsigned B. B ≥ NB_DATA gives 0.
  - Any other code: result 0.
- o_led = ALU result.
- Reset: reg_a, reg_b and reg_op all clear to 0. Op 0 is unsupported, so o_led = 0 during and after reset.
- Reset has priority over button loads in the same cycle.

## Timing
- Register loads happen on the rising edge of i_clk where the load condition is true.
- o_led reflects new register contents combinationally after that same edge. Latency from sampled load to valid result is one clock edge.
- Reset asserted mid-sequence: all registers clear on the next edge and o_led becomes 0. Loads resume on the first edge with i_reset low.
- Inputs are assumed already synchronized and debounced; none are added here.

## Configuration
- BTN_EDGE_EN defined:
  - Each button passes through a register and rising-edge detector, whose register resets to 0.
  - A register loads only on the cycle after a 0→1 transition of its button.
  - Holding a button loads exactly once; latency from button rise to o_led update is two edges.
- BTN_EDGE_EN undefined:
  - Level-sensitive load; the register reloads on every edge while the button is high.
  - Latency is one edge.

## Test plan
- Reset: assert i_reset for one or more edges with random i_sw and i_btn → o_led = 0. After release with no buttons pressed, o_led stays 0.
- ADD: load A=10, then B=5, then op=6'b100000, one button pulse each for 1 cycle with i_sw set → o_led = 15.
- SUB: load A=15, B=5, op=6'b100010 → o_led = 10. Also A=5, B=15 → o_led = 8'hF6.
- Logic and shift ops:
  - A=8'hF0, B=8'h3C: AND → 8'h30, OR → 8'hFC, XOR → 8'hCC, NOR → 8'h03.
  - A=8'h80, B=2: SRA → 8'hE0, SRL → 8'h20.
  - A=8'h80, B=9: SRA → 8'hFF, SRL → 8'h00.
- Unsupported op (6'b111111) → o_led = 0. Loading A and B with buttons [1:0] pressed together and i_sw=7, then op ADD → o_led = 14.
- Hold and edge check: hold i_btn[0] for 3 cycles while i_sw changes 1→2→3.
  - Without BTN_EDGE_EN: final A=3.
  - With BTN_EDGE_EN: A=1 only.
  - Verify with op ADD, B=0 → o_led = 3 or 1 respectively.
